// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between W-stage writeback and a late MDU result FIFO; grant is combinational.
// MDU results are eligible one cycle after push; mduReady drops when full, and stallW is raised for one cycle when the FIFO head starves.
module wb_port_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     memToRegW,
    input  logic                     regWriteW,
    input  logic [31:0]              readDataW,
    input  logic [31:0]              ALUOutW,
    input  logic [4:0]               writeRegW,
    input  logic                     mduValid,
    output logic                     mduReady,
    input  logic [4:0]               mduReg,
    input  logic [31:0]              mduData,
    input  logic [4:0]               rsD,
    input  logic [4:0]               rtD,
    output logic                     pendHazardD,
    output logic                     stallW,
    output logic [31:0]              resultW,
    output logic                     rfWe,
    output logic [4:0]               rfWa,
    output logic [31:0]              rfWd,
    output logic [$clog2(DEPTH):0]   fifoCount
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    r_reg [DEPTH];
    logic [31:0]   r_dat [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [WW-1:0] r_wait;
    logic          r_stall;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_pipe_wants;
    logic [4:0]    w_head_reg;
    logic [31:0]   w_head_dat;
    logic          w_stall_nxt;
    logic [AW-1:0] w_slot_off;
    logic          w_hazard;

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == CW'(DEPTH));
    assign mduReady     = !w_full;
    assign w_push       = mduValid && !w_full;
    assign w_pipe_wants = regWriteW && (writeRegW != 5'd0);
    assign w_head_reg   = r_reg[r_rptr];
    assign w_head_dat   = r_dat[r_rptr];
    assign resultW      = memToRegW ? readDataW : ALUOutW;
    assign stallW       = r_stall;
    assign fifoCount    = r_count;
    assign pendHazardD  = w_hazard;

    // A stalled W stage is frozen upstream, so the FIFO head can take the port without losing the W write.
    always_comb begin
        rfWe  = 1'b0;
        rfWa  = 5'd0;
        rfWd  = 32'd0;
        w_pop = 1'b0;
        if (r_stall && !w_empty) begin
            w_pop = 1'b1;
            rfWe  = (w_head_reg != 5'd0);
            rfWa  = w_head_reg;
            rfWd  = w_head_dat;
        end else if (w_pipe_wants) begin
            rfWe  = 1'b1;
            rfWa  = writeRegW;
            rfWd  = resultW;
        end else if (!w_empty) begin
            w_pop = 1'b1;
            rfWe  = (w_head_reg != 5'd0);
            rfWa  = w_head_reg;
            rfWd  = w_head_dat;
        end
    end

    assign w_stall_nxt = !w_empty && !w_pop && (r_wait == WW'(STARVE_LIMIT - 1));

    // Only occupied slots (offset from the read pointer below the count) may flag a hazard.
    always_comb begin
        w_hazard   = 1'b0;
        w_slot_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_slot_off = AW'(i) - r_rptr;
            if (({1'b0, w_slot_off} < r_count) &&
                (((rsD != 5'd0) && (r_reg[i] == rsD)) ||
                 ((rtD != 5'd0) && (r_reg[i] == rtD)))) begin
                w_hazard = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_reg[r_wptr] <= mduReg;
            r_dat[r_wptr] <= mduData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_wait  <= '0;
            r_stall <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_empty || w_pop) begin
                r_wait <= '0;
            end else begin
                r_wait <= r_wait + WW'(1);
            end
            r_stall <= w_stall_nxt;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with hand-computed expectations (DEPTH=4, STARVE_LIMIT=8).
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        memToRegW;
    logic        regWriteW;
    logic [31:0] readDataW;
    logic [31:0] ALUOutW;
    logic [4:0]  writeRegW;
    logic        mduValid;
    logic        mduReady;
    logic [4:0]  mduReg;
    logic [31:0] mduData;
    logic [4:0]  rsD;
    logic [4:0]  rtD;
    logic        pendHazardD;
    logic        stallW;
    logic [31:0] resultW;
    logic        rfWe;
    logic [4:0]  rfWa;
    logic [31:0] rfWd;
    logic [2:0]  fifoCount;

    int n_checks;
    int n_errors;

    wb_port_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .memToRegW   (memToRegW),
        .regWriteW   (regWriteW),
        .readDataW   (readDataW),
        .ALUOutW     (ALUOutW),
        .writeRegW   (writeRegW),
        .mduValid    (mduValid),
        .mduReady    (mduReady),
        .mduReg      (mduReg),
        .mduData     (mduData),
        .rsD         (rsD),
        .rtD         (rtD),
        .pendHazardD (pendHazardD),
        .stallW      (stallW),
        .resultW     (resultW),
        .rfWe        (rfWe),
        .rfWa        (rfWa),
        .rfWd        (rfWd),
        .fifoCount   (fifoCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        memToRegW = 1'b0;
        regWriteW = 1'b0;
        readDataW = 32'd0;
        ALUOutW   = 32'd0;
        writeRegW = 5'd0;
        mduValid  = 1'b0;
        mduReg    = 5'd0;
        mduData   = 32'd0;
        rsD       = 5'd0;
        rtD       = 5'd0;
        tick();
        tick();
        check("rst_count", 32'(fifoCount), 32'd0);
        check("rst_stall", 32'(stallW), 32'd0);
        check("rst_ready", 32'(mduReady), 32'd1);
        check("rst_hazard", 32'(pendHazardD), 32'd0);
        check("rst_we", 32'(rfWe), 32'd0);
        check("rst_wa", 32'(rfWa), 32'd0);
        check("rst_wd", rfWd, 32'd0);
        rst_n = 1'b1;
        tick();

        // Pipeline-only writes
        memToRegW = 1'b0; regWriteW = 1'b1; ALUOutW = 32'd3; readDataW = 32'd1; writeRegW = 5'd5;
        #1;
        check("pipe_result", resultW, 32'd3);
        check("pipe_we", 32'(rfWe), 32'd1);
        check("pipe_wa", 32'(rfWa), 32'd5);
        check("pipe_wd", rfWd, 32'd3);
        memToRegW = 1'b1;
        #1;
        check("pipe_load_wd", rfWd, 32'd1);
        writeRegW = 5'd0;
        #1;
        check("pipe_r0_we", 32'(rfWe), 32'd0);

        // Idle drain of a single MDU result
        regWriteW = 1'b0; memToRegW = 1'b0;
        mduValid = 1'b1; mduReg = 5'd9; mduData = 32'hDEAD;
        #1;
        check("drain_not_yet", 32'(rfWe), 32'd0);
        tick();
        mduValid = 1'b0;
        check("drain_count1", 32'(fifoCount), 32'd1);
        check("drain_we", 32'(rfWe), 32'd1);
        check("drain_wa", 32'(rfWa), 32'd9);
        check("drain_wd", rfWd, 32'hDEAD);
        tick();
        check("drain_count0", 32'(fifoCount), 32'd0);
        check("drain_idle_we", 32'(rfWe), 32'd0);

        // Fill the FIFO while the pipeline owns the port
        regWriteW = 1'b1; writeRegW = 5'd5; ALUOutW = 32'h55;
        mduValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mduReg  = 5'(10 + i);
            mduData = 32'h100 + 32'(i);
            tick();
        end
        check("full_count", 32'(fifoCount), 32'd4);
        check("full_ready", 32'(mduReady), 32'd0);
        mduReg = 5'd20; mduData = 32'h200;
        tick();
        mduValid = 1'b0;
        check("full_reject", 32'(fifoCount), 32'd4);
        check("full_pipe_wa", 32'(rfWa), 32'd5);
        regWriteW = 1'b0;
        #1;
        check("full_pop_wa", 32'(rfWa), 32'd10);
        check("full_pop_wd", rfWd, 32'h100);
        tick();
        check("full_count3", 32'(fifoCount), 32'd3);
        check("full_ready_again", 32'(mduReady), 32'd1);

        // Asynchronous reset with three entries queued
        rst_n = 1'b0;
        #1;
        check("arst_count", 32'(fifoCount), 32'd0);
        check("arst_stall", 32'(stallW), 32'd0);
        check("arst_ready", 32'(mduReady), 32'd1);
        check("arst_we", 32'(rfWe), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Starvation: head waits 8 cycles, stall on the 9th
        regWriteW = 1'b1; writeRegW = 5'd5; ALUOutW = 32'h77; memToRegW = 1'b0;
        mduValid = 1'b1; mduReg = 5'd12; mduData = 32'hBEEF;
        tick();
        mduValid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("starve_nostall_c%0d", k), 32'(stallW), 32'd0);
            check($sformatf("starve_pipe_wa_c%0d", k), 32'(rfWa), 32'd5);
            tick();
        end
        check("starve_stall", 32'(stallW), 32'd1);
        check("starve_we", 32'(rfWe), 32'd1);
        check("starve_wa", 32'(rfWa), 32'd12);
        check("starve_wd", rfWd, 32'hBEEF);
        tick();
        check("starve_clear", 32'(stallW), 32'd0);
        check("starve_count", 32'(fifoCount), 32'd0);
        check("starve_w_wa", 32'(rfWa), 32'd5);
        check("starve_w_wd", rfWd, 32'h77);

        // Hazard detection
        mduValid = 1'b1; mduReg = 5'd7; mduData = 32'h1; rsD = 5'd7; rtD = 5'd0;
        #1;
        check("haz_push_not_yet", 32'(pendHazardD), 32'd0);
        tick();
        mduValid = 1'b0;
        check("haz_rs", 32'(pendHazardD), 32'd1);
        rsD = 5'd0; rtD = 5'd7;
        #1;
        check("haz_rt", 32'(pendHazardD), 32'd1);
        rtD = 5'd3;
        #1;
        check("haz_nomatch", 32'(pendHazardD), 32'd0);
        rtD = 5'd7; regWriteW = 1'b0;
        #1;
        check("haz_pop_wa", 32'(rfWa), 32'd7);
        check("haz_popping", 32'(pendHazardD), 32'd1);
        tick();
        check("haz_cleared", 32'(pendHazardD), 32'd0);
        check("haz_count0", 32'(fifoCount), 32'd0);

        regWriteW = 1'b1; rsD = 5'd0; rtD = 5'd0;
        mduValid = 1'b1; mduReg = 5'd0; mduData = 32'h5;
        tick();
        mduValid = 1'b0;
        check("haz_r0_count", 32'(fifoCount), 32'd1);
        check("haz_r0", 32'(pendHazardD), 32'd0);
        regWriteW = 1'b0;
        #1;
        check("r0_pop_we", 32'(rfWe), 32'd0);
        tick();
        check("r0_popped", 32'(fifoCount), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
